// File: rtl/mat4_mac_sequencer_pkg.sv
// rtl/mat4_mac_sequencer_pkg.sv - shared constants and state encoding for the 4x4 matrix multiplier
package mat4_mac_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MAC  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    localparam int MAT_DIM     = 4;
    localparam int MAT_ELEMS   = MAT_DIM * MAT_DIM;
    localparam int LOAD_ELEMS  = 2 * MAT_ELEMS;
    localparam int DIM_IDX_W   = $clog2(MAT_DIM);
    localparam int ELEM_IDX_W  = $clog2(MAT_ELEMS);
    localparam int LOAD_CNT_W  = $clog2(LOAD_ELEMS);

endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - signed multiply, sign-extend and accumulate for one dot-product step
module mac_unit #(
    parameter int Width    = 8,
    parameter int AccWidth = 2 * Width + 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       first,
    input  logic signed [Width-1:0]    a,
    input  logic signed [Width-1:0]    b,
    output logic signed [AccWidth-1:0] acc_next
);

    logic signed [2*Width-1:0]  prod;
    logic signed [AccWidth-1:0] prod_ext;
    logic signed [AccWidth-1:0] acc;

    assign prod     = a * b;
    assign prod_ext = AccWidth'(prod);
    // The first term of a dot product restarts the sum instead of adding to stale acc.
    assign acc_next = (first ? {AccWidth{1'b0}} : acc) + prod_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/twos_neg.sv
// rtl/twos_neg.sv - two's-complement negation of a Width-bit value
module twos_neg #(
    parameter int Width = 18
) (
    input  logic [Width-1:0] value,
    output logic [Width-1:0] result
);

    assign result = ~value + Width'(1);

endmodule

// File: rtl/mat4_mac_sequencer.sv
// rtl/mat4_mac_sequencer.sv - loads two 4x4 signed matrices and streams C=A*B (optionally negated)
module mat4_mac_sequencer
    import mat4_mac_sequencer_pkg::*;
#(
    parameter int Width    = 8,
    parameter int AccWidth = 2 * Width + 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       neg_en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [Width-1:0]    in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [AccWidth-1:0] out_data,
    output logic                       busy,
    output logic                       done
);

    state_t                   state, state_nxt;
    logic [LOAD_CNT_W-1:0]    load_cnt;
    logic [DIM_IDX_W-1:0]     mac_k;
    logic [DIM_IDX_W-1:0]     row;
    logic [DIM_IDX_W-1:0]     col;
    logic                     neg_lat;

    logic signed [Width-1:0]  a_bank [MAT_ELEMS];
    logic signed [Width-1:0]  b_bank [MAT_ELEMS];

    logic                     load_hs;
    logic                     out_hs;
    logic                     last_load;
    logic                     last_mac;
    logic                     last_elem;
    logic signed [Width-1:0]  a_op;
    logic signed [Width-1:0]  b_op;
    logic signed [AccWidth-1:0] acc_nxt;
    logic signed [AccWidth-1:0] acc_neg;

    assign in_ready  = (state == ST_LOAD);
    assign out_valid = (state == ST_OUT);
    assign busy      = (state != ST_IDLE);

    assign load_hs   = in_ready && in_valid;
    assign out_hs    = out_valid && out_ready;
    assign last_load = load_hs && (load_cnt == LOAD_CNT_W'(LOAD_ELEMS - 1));
    assign last_mac  = (state == ST_MAC) && (mac_k == DIM_IDX_W'(MAT_DIM - 1));
    assign last_elem = ({row, col} == ELEM_IDX_W'(MAT_ELEMS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)     state_nxt = ST_LOAD;
            ST_LOAD: if (last_load) state_nxt = ST_MAC;
            ST_MAC:  if (last_mac)  state_nxt = ST_OUT;
            ST_OUT:  if (out_ready) state_nxt = last_elem ? ST_IDLE : ST_MAC;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt <= '0;
            mac_k    <= '0;
            row      <= '0;
            col      <= '0;
            neg_lat  <= 1'b0;
            out_data <= '0;
            done     <= 1'b0;
        end else begin
            done <= out_hs && last_elem;
            if ((state == ST_IDLE) && start) begin
                neg_lat  <= neg_en;
                load_cnt <= '0;
                mac_k    <= '0;
                row      <= '0;
                col      <= '0;
            end
            if (load_hs) begin
                load_cnt <= load_cnt + LOAD_CNT_W'(1);
            end
            if (state == ST_MAC) begin
                mac_k <= mac_k + DIM_IDX_W'(1);
            end
            // The final sum is captured straight from the adder so OUT sees it one cycle after k=3.
            if (last_mac) begin
                out_data <= neg_lat ? acc_neg : acc_nxt;
            end
            if (out_hs) begin
                {row, col} <= {row, col} + ELEM_IDX_W'(1);
            end
        end
    end

    // Matrix banks are deliberately left out of reset; every job reloads them fully.
    always_ff @(posedge clk) begin
        if (load_hs) begin
            if (!load_cnt[LOAD_CNT_W-1]) begin
                a_bank[load_cnt[ELEM_IDX_W-1:0]] <= in_data;
            end else begin
                b_bank[load_cnt[ELEM_IDX_W-1:0]] <= in_data;
            end
        end
    end

    assign a_op = a_bank[{row, mac_k}];
    assign b_op = b_bank[{mac_k, col}];

    mac_unit #(
        .Width    (Width),
        .AccWidth (AccWidth)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state == ST_MAC),
        .first    (mac_k == '0),
        .a        (a_op),
        .b        (b_op),
        .acc_next (acc_nxt)
    );

    twos_neg #(
        .Width (AccWidth)
    ) u_neg (
        .value  (acc_nxt),
        .result (acc_neg)
    );

endmodule
